reorder_buffer: RTL
===================

# reorder_buffer

In-order commit buffer that is the writer side of the architectural register-file write port (valid / rd / wdata). It allocates entries in program order at issue and captures results from the common write-back bus. It retires completed entries strictly in order, one per cycle, and issues one register write per retired entry. On a mispredicted branch it discards all younger work and emits a redirect PC.

## Interface
Parameters:
- ROB_WIDTH, 3, log2 of entry count (default 8 entries)

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global enable; low = all state frozen, output pulses forced 0
- alloc_valid  input  1  issue requests an entry this cycle
- alloc_has_rd  input  1  instruction writes a register
- alloc_rd  input  5  destination register
- alloc_is_branch  input  1  entry is a conditional branch
- alloc_pred_taken  input  1  predicted direction
- alloc_tag  output  ROB_WIDTH  index the next allocation receives (current tail)
- full  output  1  no free entry; alloc ignored
- empty  output  1  no occupied entry
- wb_valid  input  1  result broadcast
- wb_tag  input  ROB_WIDTH  entry being completed
- wb_data  input  32  result value
- wb_taken  input  1  actual branch direction (don't-care for non-branch)
- wb_redirect_pc  input  32  correct next PC if mispredicted
- to_reg_valid  output  1  one-cycle register write pulse
- to_reg_rd  output  5  register written
- to_reg_wdata  output  32  value written
- flush_valid  output  1  one-cycle mispredict pulse
- flush_pc  output  32  redirect target

## Operation
- Per entry: busy, ready, has_rd, rd, is_branch, pred_taken, actual_taken, data[31:0], redirect_pc[31:0].
- Pointers head and tail are ROB_WIDTH bits wide and wrap modulo 2^ROB_WIDTH. count is ROB_WIDTH+1 bits.
- full = (count == 2^ROB_WIDTH). empty = (count == 0). Both are derived from the registered count, so a commit in the same cycle does not free a slot for that cycle's alloc.
- Alloc, when alloc_valid && !full:
  - Write the entry at tail with busy=1 and ready=0.
  - tail++.
- Write-back, when wb_valid && entry[wb_tag].busy:
  - Set ready=1, data, actual_taken, redirect_pc.
  - Write-back to a non-busy entry is ignored.
- Commit, when entry[head].busy && entry[head].ready (registered bit):
  - Clear busy and advance head.
  - If has_rd && rd != 0: to_reg_valid=1, to_reg_rd=rd, to_reg_wdata=data. Otherwise no write pulse; the entry still retires.
  - If is_branch && actual_taken != pred_taken: flush_valid=1 and flush_pc=redirect_pc. Clear every busy bit, set head=tail=0 and count=0.
  - A same-cycle alloc and any same-cycle wb are discarded on a flush.
- count update: +alloc_accepted −commit. On flush, count is forced to 0.
- rdy_in low: no alloc, wb, or commit takes effect; to_reg_valid=0 and flush_valid=0.

## Timing
- Reset (rst_in high at a rising edge): head=tail=count=0 and all busy=0. to_reg_valid=0, to_reg_rd=0, to_reg_wdata=0, flush_valid=0, flush_pc=0, full=0, empty=1, alloc_tag=0. Reset overrides every same-cycle event.
- All outputs are registered except full, empty and alloc_tag, which are direct decodes of state.
- Write-back at edge t makes the entry committable at edge t+1. If it is head, to_reg_valid is high during cycle t+1→t+2. Minimum wb-to-register-write latency is 2 edges.
- Throughput: one alloc and one commit per cycle.
- A write-back at the cycle of commit to a different tag is accepted normally.
- flush_valid and to_reg_valid can both pulse in the same cycle, for a branch with rd.

## Structure
- Package rob_pkg holds:
  - entry struct
  - ROB_WIDTH default
  - ROB_SIZE = 1 << ROB_WIDTH
  - X0 = 5'd0
- Single module; no sub-module needed. Entry storage is a flop array, because write-back must update arbitrary entries in parallel with alloc and commit.

## Test plan
- Reset, alloc 3 non-branch (rd=1,2,3), wb tags 2,0,1 with data 0x11,0x22,0x33 → writes in order: rd1=0x22, rd2=0x33, rd3=0x11, on consecutive cycles after tag 1 wb.
- Alloc 8 entries → full=1. Alloc with commit of head in the same cycle → alloc ignored, tail unchanged. Next cycle the alloc is accepted with alloc_tag=0 (wrap).
- Alloc rd=0 with wb data 0xFFFF → entry retires, to_reg_valid stays 0.
- Branch pred_taken=0, younger alloc rd=5; wb branch taken=1 with redirect 0x1000 → flush_valid with flush_pc=0x1000; rd5 never written; empty=1, alloc_tag=0.
- Hold rdy_in=0 for 3 cycles during wb/alloc activity → no state change, no pulses; resume → identical behaviour to the uninterrupted run.
- Assert rst_in mid-stream with 5 busy entries → next cycle empty=1, all outputs 0, a stale wb to tag 2 is ignored.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the in-order reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_WIDTH_DEF = 3;
    localparam int unsigned ROB_SIZE      = 1 << ROB_WIDTH_DEF;
    localparam logic [4:0]  X0            = 5'd0;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        has_rd;
        logic [4:0]  rd;
        logic        is_branch;
        logic        pred_taken;
        logic        actual_taken;
        logic [31:0] data;
        logic [31:0] redirect_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates at issue, captures write-back results,
// retires one entry per cycle to the register file and redirects on mispredict.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 alloc_valid,
    input  logic                 alloc_has_rd,
    input  logic [4:0]           alloc_rd,
    input  logic                 alloc_is_branch,
    input  logic                 alloc_pred_taken,
    output logic [ROB_WIDTH-1:0] alloc_tag,
    output logic                 full,
    output logic                 empty,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_data,
    input  logic                 wb_taken,
    input  logic [31:0]          wb_redirect_pc,
    output logic                 to_reg_valid,
    output logic [4:0]           to_reg_rd,
    output logic [31:0]          to_reg_wdata,
    output logic                 flush_valid,
    output logic [31:0]          flush_pc
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam int unsigned CNT_W = ROB_WIDTH + 1;

    rob_entry_t           entries_q [DEPTH];
    rob_entry_t           entries_d [DEPTH];
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 to_reg_valid_q, to_reg_valid_d;
    logic [4:0]           to_reg_rd_q, to_reg_rd_d;
    logic [31:0]          to_reg_wdata_q, to_reg_wdata_d;
    logic                 flush_valid_q, flush_valid_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic                 alloc_acc;
    logic                 commit;
    logic                 mispredict;

    // full/empty come from the registered count, so a same-cycle commit never frees a slot
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign alloc_tag = tail_q;

    assign to_reg_valid = to_reg_valid_q;
    assign to_reg_rd    = to_reg_rd_q;
    assign to_reg_wdata = to_reg_wdata_q;
    assign flush_valid  = flush_valid_q;
    assign flush_pc     = flush_pc_q;

    // Next-state: write-back, alloc and commit act on disjoint entries; a flush discards all
    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        to_reg_valid_d = 1'b0;
        to_reg_rd_d    = to_reg_rd_q;
        to_reg_wdata_d = to_reg_wdata_q;
        flush_valid_d  = 1'b0;
        flush_pc_d     = flush_pc_q;
        alloc_acc      = 1'b0;
        commit         = 1'b0;
        mispredict     = 1'b0;

        if (rdy_in) begin
            alloc_acc  = alloc_valid && !full;
            commit     = entries_q[head_q].busy && entries_q[head_q].ready;
            mispredict = commit && entries_q[head_q].is_branch &&
                         (entries_q[head_q].actual_taken != entries_q[head_q].pred_taken);

            if (wb_valid && entries_q[wb_tag].busy) begin
                entries_d[wb_tag].ready        = 1'b1;
                entries_d[wb_tag].data         = wb_data;
                entries_d[wb_tag].actual_taken = wb_taken;
                entries_d[wb_tag].redirect_pc  = wb_redirect_pc;
            end

            if (alloc_acc) begin
                entries_d[tail_q].busy         = 1'b1;
                entries_d[tail_q].ready        = 1'b0;
                entries_d[tail_q].has_rd       = alloc_has_rd;
                entries_d[tail_q].rd           = alloc_rd;
                entries_d[tail_q].is_branch    = alloc_is_branch;
                entries_d[tail_q].pred_taken   = alloc_pred_taken;
                entries_d[tail_q].actual_taken = 1'b0;
                tail_d                         = tail_q + ROB_WIDTH'(1);
            end

            if (commit) begin
                entries_d[head_q].busy = 1'b0;
                head_d                 = head_q + ROB_WIDTH'(1);
                if (entries_q[head_q].has_rd && (entries_q[head_q].rd != X0)) begin
                    to_reg_valid_d = 1'b1;
                    to_reg_rd_d    = entries_q[head_q].rd;
                    to_reg_wdata_d = entries_q[head_q].data;
                end
            end

            count_d = count_q + CNT_W'(alloc_acc) - CNT_W'(commit);

            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries_d[i].busy = 1'b0;
                end
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
                flush_valid_d = 1'b1;
                flush_pc_d    = entries_q[head_q].redirect_pc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            to_reg_valid_q <= 1'b0;
            to_reg_rd_q    <= '0;
            to_reg_wdata_q <= '0;
            flush_valid_q  <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            to_reg_valid_q <= to_reg_valid_d;
            to_reg_rd_q    <= to_reg_rd_d;
            to_reg_wdata_q <= to_reg_wdata_d;
            flush_valid_q  <= flush_valid_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

endmodule
